// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer that owns the select lines of a shared 4:1 single-bit mux.
// Grant, select and data are registered one cycle after request; a hold limit forces rotation under contention.
module mux_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] data_in,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       sel,
  output logic             sel_valid,
  output logic             dout,
  output logic             dout_valid
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_t           state;
  logic [7:0]       hold_cnt;
  logic [1:0]       rr_ptr;
  logic [N_REQ-1:0] cand;
  logic [1:0]       idx;
  logic [1:0]       win;
  logic             found;
  logic             owner_req;
  logic             take;
  logic             keep;

  // While busy the current owner is masked out, so a rotation can never re-pick it.
  always_comb begin
    cand  = (state == IDLE) ? req : (req & ~gnt);
    found = 1'b0;
    win   = rr_ptr;
    idx   = rr_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = rr_ptr + 2'(k);
      if (cand[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    owner_req = req[sel];
    take = found && ((state == IDLE) || !owner_req || (hold_cnt >= HOLD_MAX));
    keep = (state == BUSY) && owner_req && !take;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= 8'd0;
      rr_ptr     <= 2'd0;
      gnt        <= '0;
      sel        <= 2'b00;
      sel_valid  <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end else if (take) begin
      state      <= BUSY;
      hold_cnt   <= 8'd1;
      rr_ptr     <= win + 2'd1;
      gnt        <= N_REQ'(1) << win;
      sel        <= win;
      sel_valid  <= 1'b1;
      dout       <= data_in[win];
      dout_valid <= 1'b1;
    end else if (keep) begin
      hold_cnt   <= (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 8'd1;
      dout       <= data_in[sel];
      dout_valid <= 1'b1;
    end else begin
      // Nobody wants the mux: release the grant but leave sel where it was.
      state      <= IDLE;
      gnt        <= '0;
      sel_valid  <= 1'b0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
    end
  end

endmodule
